// File: rtl/pending_bits_flusher_if.sv
// pending_bits_flusher_if
//   Bundles the word-input, pending-increment, beat-output and status
//   signals of pending_bits_flusher.
//   master: the side that offers words/increments and consumes beats.
//   slave : the flusher itself.
//   Signals:
//     bits_in/bits_count_in/bits_valid_in/bits_ready_out : word input handshake
//     pending_in/pending_valid_in                        : pending increment strobe
//     bits_out/bits_count_out/bits_valid_out/bits_ready_in : beat output handshake
//     pending_overflow, busy                             : status
interface pending_bits_flusher_if #(
  parameter int W   = 16,
  parameter int CW  = $clog2(W + 1),
  parameter int PIW = 4
);
  logic [W-1:0]   bits_in;
  logic [CW-1:0]  bits_count_in;
  logic           bits_valid_in;
  logic           bits_ready_out;
  logic [PIW-1:0] pending_in;
  logic           pending_valid_in;
  logic [W-1:0]   bits_out;
  logic [CW-1:0]  bits_count_out;
  logic           bits_valid_out;
  logic           bits_ready_in;
  logic           pending_overflow;
  logic           busy;

  modport master (
    output bits_in, bits_count_in, bits_valid_in, pending_in, pending_valid_in,
    output bits_ready_in,
    input  bits_ready_out, bits_out, bits_count_out, bits_valid_out,
    input  pending_overflow, busy
  );

  modport slave (
    input  bits_in, bits_count_in, bits_valid_in, pending_in, pending_valid_in,
    input  bits_ready_in,
    output bits_ready_out, bits_out, bits_count_out, bits_valid_out,
    output pending_overflow, busy
  );
endinterface

// File: rtl/pending_bits_flusher.sv
// pending_bits_flusher
//   Accumulates pending (underflow) bit counts from the arithmetic encoder and
//   expands each accepted code word into the stream
//     b, Ps copies of ~b, remaining C-1 code bits
//   emitted as MSB-aligned beats under a valid/ready handshake.
//   Ports:
//     clk  : clock, everything on posedge
//     rst  : synchronous active-high reset
//     bus  : pending_bits_flusher_if.slave (word in, pending strobe,
//            beat out, pending_overflow, busy)
module pending_bits_flusher #(
  parameter int W   = 16,
  parameter int CW  = $clog2(W + 1),
  parameter int PW  = 16,
  parameter int PIW = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pending_bits_flusher_if.slave   bus
);

  // The HEAD beat is loaded on the accept edge itself, so the state register
  // only records which kind of beat must be loaded next.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_TAIL
  } state_t;

  localparam int unsigned W_U  = 32'(W);
  localparam int unsigned W_M1 = 32'(W - 1);
  localparam logic [W-1:0] MSB_ONLY = {1'b1, {(W-1){1'b0}}};

  // Top n bits set; n >= W gives all ones.
  function automatic logic [W-1:0] top_mask(input int unsigned n);
    top_mask = ~({W{1'b1}} >> n);
  endfunction

  state_t          state_q, state_d;
  logic [PW-1:0]   p_q, p_d;
  logic [PW-1:0]   rem_q, rem_d;
  logic            ovf_q, ovf_d;
  logic            inv_q, inv_d;
  logic [W-1:0]    tail_q, tail_d;
  logic [CW-1:0]   tail_cnt_q, tail_cnt_d;
  logic [W-1:0]    out_q, out_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic            out_valid_q, out_valid_d;

  logic            load_ok;
  logic            ready;
  logic            word_live;
  logic            b;
  logic [PW:0]     p_sum;
  int unsigned     cnt_u;
  int unsigned     ps_u;
  int unsigned     head_k;
  int unsigned     rem_u;
  int unsigned     run_k;
  logic [PW-1:0]   rem_after_head;
  logic [PW-1:0]   rem_after_run;
  logic [W-1:0]    head_data;
  logic [W-1:0]    run_data;

  // Handshake: ready depends only on state and bits_ready_in, never on
  // bits_valid_in.
  always_comb begin
    load_ok   = !out_valid_q || bus.bits_ready_in;
    ready     = (state_q == ST_IDLE) && load_ok;
    word_live = bus.bits_valid_in && ready && (bus.bits_count_in != '0);
    b         = bus.bits_in[W-1];
  end

  // Beat arithmetic shared by the FSM.
  always_comb begin
    cnt_u  = 32'(bus.bits_count_in);
    ps_u   = 32'(p_q);
    head_k = (ps_u < W_M1) ? ps_u : W_M1;
    rem_after_head = PW'(ps_u - head_k);
    // b = 1: MSB set, copies are zero; b = 0: MSB clear, copies are ones.
    head_data = b ? MSB_ONLY : (top_mask(head_k + 32'd1) & ~MSB_ONLY);

    rem_u    = 32'(rem_q);
    run_k    = (rem_u < W_U) ? rem_u : W_U;
    run_data = inv_q ? top_mask(run_k) : '0;
    rem_after_run = rem_q - PW'(run_k);
  end

  // Pending accumulator. An increment arriving with an accepted word belongs
  // to the next word, so it replaces rather than adds to the snapshot value.
  always_comb begin
    p_d   = p_q;
    ovf_d = ovf_q;
    p_sum = {1'b0, p_q} + (PW+1)'(bus.pending_in);
    if (word_live) begin
      p_d = bus.pending_valid_in ? PW'(bus.pending_in) : '0;
    end else if (bus.pending_valid_in) begin
      if (p_sum[PW]) begin
        p_d   = '1;
        ovf_d = 1'b1;
      end else begin
        p_d = p_sum[PW-1:0];
      end
    end
  end

  // Next-state and beat register logic.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    inv_d       = inv_q;
    tail_d      = tail_q;
    tail_cnt_d  = tail_cnt_q;
    out_d       = out_q;
    out_cnt_d   = out_cnt_q;
    out_valid_d = out_valid_q;

    if (load_ok) begin
      // Held beat is consumed (or absent); invalid unless a new one loads.
      out_valid_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (word_live) begin
            out_valid_d = 1'b1;
            inv_d       = ~b;
            tail_d      = (bus.bits_in << 1) & top_mask(cnt_u - 32'd1);
            tail_cnt_d  = bus.bits_count_in - CW'(1);
            if (p_q == '0) begin
              // No pending bits: the word goes out as a single beat.
              out_d     = bus.bits_in & top_mask(cnt_u);
              out_cnt_d = bus.bits_count_in;
              state_d   = ST_IDLE;
            end else begin
              out_d     = head_data;
              out_cnt_d = CW'(head_k + 32'd1);
              rem_d     = rem_after_head;
              if (rem_after_head != '0) begin
                state_d = ST_RUN;
              end else if (bus.bits_count_in > CW'(1)) begin
                state_d = ST_TAIL;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end
        end
        ST_RUN: begin
          out_valid_d = 1'b1;
          out_d       = run_data;
          out_cnt_d   = CW'(run_k);
          rem_d       = rem_after_run;
          if (rem_after_run != '0) begin
            state_d = ST_RUN;
          end else if (tail_cnt_q != '0) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_TAIL: begin
          out_valid_d = 1'b1;
          out_d       = tail_q;
          out_cnt_d   = tail_cnt_q;
          state_d     = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      p_q         <= '0;
      rem_q       <= '0;
      ovf_q       <= 1'b0;
      inv_q       <= 1'b0;
      tail_q      <= '0;
      tail_cnt_q  <= '0;
      out_q       <= '0;
      out_cnt_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      p_q         <= p_d;
      rem_q       <= rem_d;
      ovf_q       <= ovf_d;
      inv_q       <= inv_d;
      tail_q      <= tail_d;
      tail_cnt_q  <= tail_cnt_d;
      out_q       <= out_d;
      out_cnt_q   <= out_cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.bits_ready_out   = ready;
  assign bus.bits_out         = out_q;
  assign bus.bits_count_out   = out_cnt_q;
  assign bus.bits_valid_out   = out_valid_q;
  assign bus.pending_overflow = ovf_q;
  assign bus.busy             = (state_q != ST_IDLE) || out_valid_q;

endmodule

// File: tb/tb_pending_bits_flusher.sv
// tb_pending_bits_flusher
//   Directed stimulus for two flusher instances: the default W=16/PW=16 one
//   checked every cycle against a bit-stream model, and a W=8/PW=4 one used
//   for accumulator saturation and reset-during-expansion.
module tb_pending_bits_flusher;
  localparam int W   = 16;
  localparam int CW  = 5;
  localparam int PW  = 16;
  localparam int PIW = 4;
  localparam int W4  = 8;
  localparam int CW4 = 4;
  localparam int PW4 = 4;
  localparam int unsigned PMAX = (1 << PW) - 1;

  logic clk = 1'b0;
  logic rst;
  logic rst4;
  always #5 clk = ~clk;

  pending_bits_flusher_if #(.W(W),  .CW(CW),  .PIW(PIW)) bus ();
  pending_bits_flusher_if #(.W(W4), .CW(CW4), .PIW(PIW)) bus4 ();

  pending_bits_flusher #(.W(W), .CW(CW), .PW(PW), .PIW(PIW)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );
  pending_bits_flusher #(.W(W4), .CW(CW4), .PW(PW4), .PIW(PIW)) dut4 (
    .clk(clk), .rst(rst4), .bus(bus4)
  );

  typedef struct {
    logic [W-1:0] d;
    int           c;
  } beat_t;

  int          checks   = 0;
  int          failures = 0;
  beat_t       exp_q[$];
  beat_t       seen[$];
  int unsigned m_p = 0;
  bit          m_ovf = 1'b0;
  bit          started = 1'b0;
  bit          toggle_mode = 1'b0;
  bit          ready_hold = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic bound_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Model: build the word's whole bit stream, then cut it at beat boundaries.
  function automatic logic stream_bit(input logic [W-1:0] d, input int unsigned ps, input int unsigned j);
    if (j == 0) return d[W-1];
    if (j <= ps) return ~d[W-1];
    return d[W-1-(j-ps)];
  endfunction

  function automatic void expand(input logic [W-1:0] d, input int c, input int unsigned ps);
    int unsigned lens[$];
    int unsigned k;
    int unsigned r;
    int unsigned n;
    int unsigned j;
    beat_t bt;
    if (ps == 0) begin
      lens.push_back(c);
    end else begin
      k = (ps < W - 1) ? ps : W - 1;
      lens.push_back(1 + k);
      r = ps - k;
      while (r > 0) begin
        n = (r < W) ? r : W;
        lens.push_back(n);
        r -= n;
      end
      if (c > 1) lens.push_back(c - 1);
    end
    j = 0;
    foreach (lens[i]) begin
      bt.d = '0;
      bt.c = int'(lens[i]);
      for (int t = 0; t < int'(lens[i]); t++) begin
        bt.d[W-1-t] = stream_bit(d, ps, j);
        j++;
      end
      exp_q.push_back(bt);
    end
  endfunction

  // Per-cycle compare on the falling edge, then advance the model to the
  // state after the coming rising edge.
  always @(negedge clk) begin : cmp
    bit          exp_ready;
    int unsigned sum;
    beat_t       ob;
    if (started) begin
      exp_ready = (exp_q.size() == 0) || (exp_q.size() == 1 && bus.bits_ready_in);
      check("valid_out", bus.bits_valid_out, exp_q.size() != 0);
      check("ready_out", bus.bits_ready_out, exp_ready);
      check("busy", bus.busy, exp_q.size() != 0);
      check("overflow", bus.pending_overflow, m_ovf);
      if (exp_q.size() != 0) begin
        check("beat_data", bus.bits_out, exp_q[0].d);
        check("beat_count", bus.bits_count_out, exp_q[0].c);
      end
      if (rst) begin
        exp_q.delete();
        m_p   = 0;
        m_ovf = 1'b0;
      end else begin
        if (bus.bits_valid_out && bus.bits_ready_in) begin
          ob.d = bus.bits_out;
          ob.c = int'(bus.bits_count_out);
          seen.push_back(ob);
        end
        if (exp_q.size() != 0 && bus.bits_ready_in) void'(exp_q.pop_front());
        if (bus.bits_valid_in && exp_ready && bus.bits_count_in != 0) begin
          expand(bus.bits_in, int'(bus.bits_count_in), m_p);
          m_p = bus.pending_valid_in ? int'(bus.pending_in) : 0;
        end else if (bus.pending_valid_in) begin
          sum = m_p + bus.pending_in;
          if (sum > PMAX) begin
            m_p   = PMAX;
            m_ovf = 1'b1;
          end else begin
            m_p = sum;
          end
        end
      end
    end
  end

  // Downstream ready: fixed level or toggling every cycle.
  initial begin
    bus.bits_ready_in = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.bits_ready_in = toggle_mode ? ~bus.bits_ready_in : ready_hold;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pend(input int v);
    bus.pending_valid_in = 1'b1;
    bus.pending_in       = PIW'(v);
    @(posedge clk);
    #1;
    bus.pending_valid_in = 1'b0;
    bus.pending_in       = '0;
    #1;
  endtask

  task automatic send_word(input logic [W-1:0] d, input int c, input bit ps_en, input int ps_v);
    int n = 0;
    while (!bus.bits_ready_out && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) bound_fail("ready_wait");
    bus.bits_in          = d;
    bus.bits_count_in    = CW'(c);
    bus.bits_valid_in    = 1'b1;
    bus.pending_valid_in = ps_en;
    bus.pending_in       = PIW'(ps_v);
    @(posedge clk);
    #1;
    bus.bits_valid_in    = 1'b0;
    bus.pending_valid_in = 1'b0;
    bus.pending_in       = '0;
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 500) begin
      step();
      n++;
    end
    if (n >= 500) bound_fail("drain_wait");
  endtask

  task automatic expect_seen(input string name, input int idx, input logic [W-1:0] d, input int c);
    if (idx >= seen.size()) begin
      bound_fail(name);
    end else begin
      check({name, "_data"}, seen[idx].d, d);
      check({name, "_count"}, seen[idx].c, c);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0;
    rst = 1'b1;
    rst4 = 1'b1;
    bus.bits_in = '0;  bus.bits_count_in = '0;  bus.bits_valid_in = 1'b0;
    bus.pending_in = '0;  bus.pending_valid_in = 1'b0;
    bus4.bits_in = '0; bus4.bits_count_in = '0; bus4.bits_valid_in = 1'b0;
    bus4.pending_in = '0; bus4.pending_valid_in = 1'b0; bus4.bits_ready_in = 1'b0;
    step();
    step();
    started = 1'b1;

    // Reset state.
    check("rst_bits_out", bus.bits_out, 0);
    check("rst_count_out", bus.bits_count_out, 0);
    check("rst_valid_out", bus.bits_valid_out, 0);
    check("rst_overflow", bus.pending_overflow, 0);
    check("rst_busy", bus.busy, 0);
    rst = 1'b0;
    step();
    check("rst_ready_after", bus.bits_ready_out, 1);

    // Plain word, no pending bits; beat valid right after the accept edge.
    seen.delete();
    send_word(16'hA000, 3, 0, 0);
    check("first_latency_valid", bus.bits_valid_out, 1);
    wait_idle();
    check("a_beats", seen.size(), 1);
    expect_seen("a0", 0, 16'hA000, 3);

    // P = 5, C = 1: one beat 1 followed by five zeros; then P is back to 0.
    seen.delete();
    pend(3);
    pend(2);
    send_word(16'h8000, 1, 0, 0);
    send_word(16'h4000, 2, 0, 0);
    wait_idle();
    check("b_beats", seen.size(), 2);
    expect_seen("b0", 0, 16'h8000, 6);
    expect_seen("b1", 1, 16'h4000, 2);

    // P = 20, word 11111: HEAD, RUN of 5 zeros, TAIL 1111.
    seen.delete();
    pend(15);
    pend(5);
    send_word(16'hF800, 5, 0, 0);
    wait_idle();
    check("c_beats", seen.size(), 3);
    expect_seen("c0", 0, 16'h8000, 16);
    expect_seen("c1", 1, 16'h0000, 5);
    expect_seen("c2", 2, 16'hF000, 4);

    // Same stimulus with toggling downstream ready.
    seen.delete();
    toggle_mode = 1'b1;
    pend(15);
    pend(5);
    send_word(16'hF800, 5, 0, 0);
    wait_idle();
    toggle_mode = 1'b0;
    step();
    check("d_beats", seen.size(), 3);
    expect_seen("d0", 0, 16'h8000, 16);
    expect_seen("d1", 1, 16'h0000, 5);
    expect_seen("d2", 2, 16'hF000, 4);

    // Strobe in the accept cycle belongs to the next word.
    seen.delete();
    pend(2);
    send_word(16'h0000, 1, 1, 7);
    send_word(16'h8000, 1, 0, 0);
    wait_idle();
    check("e_beats", seen.size(), 2);
    expect_seen("e0", 0, 16'h6000, 3);
    expect_seen("e1", 1, 16'h8000, 8);

    // Zero-count word: no beat, P kept, its strobe still adds.
    seen.delete();
    pend(4);
    send_word(16'h1234, 0, 1, 1);
    send_word(16'h8000, 1, 0, 0);
    wait_idle();
    check("f_beats", seen.size(), 1);
    expect_seen("f0", 0, 16'h8000, 6);

    // Back-to-back single-beat words, one per cycle, with masking.
    seen.delete();
    t0 = $time;
    send_word(16'hC000, 2, 0, 0);
    send_word(16'h123F, 12, 0, 0);
    send_word(16'hFFFF, 3, 0, 0);
    send_word(16'hFFFF, 16, 0, 0);
    send_word(16'h0001, 16, 0, 0);
    check("g_cycles", 32'((($time - t0) / 10)), 5);
    wait_idle();
    check("g_beats", seen.size(), 5);
    expect_seen("g0", 0, 16'hC000, 2);
    expect_seen("g1", 1, 16'h1230, 12);
    expect_seen("g2", 2, 16'hE000, 3);
    expect_seen("g3", 3, 16'hFFFF, 16);
    expect_seen("g4", 4, 16'h0001, 16);

    // b = 0 with two RUN beats of ones: P = 40, word 0101.
    seen.delete();
    pend(15);
    pend(15);
    pend(10);
    send_word(16'h5000, 4, 0, 0);
    wait_idle();
    check("h_beats", seen.size(), 4);
    expect_seen("h0", 0, 16'h7FFF, 16);
    expect_seen("h1", 1, 16'hFFFF, 16);
    expect_seen("h2", 2, 16'hFF80, 9);
    expect_seen("h3", 3, 16'hA000, 3);

    // Small instance: saturation, sticky flag, reset mid-RUN.
    check("s_rst_valid", bus4.bits_valid_out, 0);
    check("s_rst_busy", bus4.busy, 0);
    rst4 = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      bus4.pending_valid_in = 1'b1;
      bus4.pending_in = 4'd15;
      @(posedge clk);
      #1;
      bus4.pending_valid_in = 1'b0;
      bus4.pending_in = '0;
      #1;
      if (i == 0) check("s_ovf_first", bus4.pending_overflow, 0);
      if (i == 1) check("s_ovf_second", bus4.pending_overflow, 1);
    end
    check("s_ovf_after", bus4.pending_overflow, 1);
    check("s_ready_idle", bus4.bits_ready_out, 1);
    bus4.bits_in = 8'h80;
    bus4.bits_count_in = 4'd2;
    bus4.bits_valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus4.bits_valid_in = 1'b0;
    #1;
    check("s_head_data", bus4.bits_out, 8'h80);
    check("s_head_count", bus4.bits_count_out, 8);
    check("s_head_valid", bus4.bits_valid_out, 1);
    check("s_head_ready_out", bus4.bits_ready_out, 0);
    bus4.bits_ready_in = 1'b1;
    step();
    bus4.bits_ready_in = 1'b0;
    check("s_run_data", bus4.bits_out, 8'h00);
    check("s_run_count", bus4.bits_count_out, 8);
    check("s_run_valid", bus4.bits_valid_out, 1);
    check("s_ovf_sticky", bus4.pending_overflow, 1);
    step();
    check("s_run_hold_count", bus4.bits_count_out, 8);
    check("s_run_busy", bus4.busy, 1);
    rst4 = 1'b1;
    step();
    check("s_abort_valid", bus4.bits_valid_out, 0);
    check("s_abort_data", bus4.bits_out, 0);
    check("s_abort_count", bus4.bits_count_out, 0);
    check("s_abort_ovf", bus4.pending_overflow, 0);
    check("s_abort_busy", bus4.busy, 0);
    rst4 = 1'b0;
    step();
    check("s_ready_after", bus4.bits_ready_out, 1);
    check("s_idle_valid", bus4.bits_valid_out, 0);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
